// File: rtl/spi_frame_capture.sv
// Deserializes MSB-first words from the delayed SPI bus into a small valid/ready FIFO,
// counting frames and flagging short frames and overflow. Optional macro: SPI_CAP_TIMEOUT_EN.
module spi_frame_capture #(
    parameter int   W       = 8,
    parameter int   DEPTH   = 4,
    parameter logic CS_ACT  = 1'b1,
    parameter int   TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sclk,
    input  logic         cs,
    input  logic         miso,
    input  logic         cs_en,
    output logic [W-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [15:0]  frame_cnt,
    output logic         short_err,
    output logic         ovf,
    output logic         to_err
);

    localparam int BW = $clog2(W);
    localparam int PW = $clog2(DEPTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);

    logic          sclk_r, sclk_r2, cs_r, miso_r, act_prev;
    logic          rise, act, start, frame_end;
    logic [BW-1:0] bit_cnt, cnt_base;
    logic [W-2:0]  shreg;
    logic [W-1:0]  shifted;
    logic          word_push;
    logic          idle_hit;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic [W-1:0]  last_q;
    logic          pop, full, push_ok;

    assign rise      = sclk_r & ~sclk_r2;
    assign act       = (cs_r == CS_ACT) & cs_en;
    assign start     = act & ~act_prev;
    assign frame_end = ~act & act_prev;

    // A word that starts on the same cycle as a frame must count from zero.
    assign cnt_base  = start ? '0 : bit_cnt;
    assign shifted   = {shreg, miso_r};
    // rise & act can never coincide with frame_end, so an ending frame never shifts.
    assign word_push = rise & act & (cnt_base == LAST_BIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_r    <= 1'b0;
            sclk_r2   <= 1'b0;
            cs_r      <= ~CS_ACT;
            miso_r    <= 1'b0;
            act_prev  <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            frame_cnt <= '0;
            short_err <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            sclk_r   <= sclk;
            sclk_r2  <= sclk_r;
            cs_r     <= cs;
            miso_r   <= miso;
            act_prev <= act;
            if (frame_end) begin
                if (bit_cnt != '0) short_err <= 1'b1;
                bit_cnt <= '0;
            end else begin
                if (start) frame_cnt <= frame_cnt + 16'd1;
                if (rise && act) begin
                    shreg   <= shifted[W-2:0];
                    bit_cnt <= (cnt_base == LAST_BIT) ? '0 : cnt_base + 1'b1;
                end else if (start) begin
                    bit_cnt <= '0;
                end else if (idle_hit) begin
                    bit_cnt <= '0;
                end
            end
        end
    end

`ifdef SPI_CAP_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);
    logic [IW-1:0] idle_cnt;
    logic          to_err_q;

    assign idle_hit = act & ~rise & ~start & (bit_cnt != '0) & (idle_cnt == IW'(TIMEOUT));
    assign to_err   = to_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
            to_err_q <= 1'b0;
        end else if (rise || start) begin
            idle_cnt <= '0;
        end else if (idle_hit) begin
            idle_cnt <= '0;
            to_err_q <= 1'b1;
        end else if (act && bit_cnt != '0) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign idle_hit = 1'b0;
    assign to_err   = 1'b0;
`endif

    assign m_valid = (count != '0);
    assign full    = (count == FULL_CNT);
    assign pop     = m_valid & m_ready;
    assign push_ok = word_push & (~full | pop);
    // Once drained, keep presenting the last word handed out rather than a stale slot.
    assign m_data  = m_valid ? mem[rd_ptr] : last_q;

    // NOTE: the storage array has no reset; occupancy and last_q define what is visible.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= shifted;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr];
            end
            if (word_push && full && !pop) ovf <= 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
